// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative multiply/divide unit (MULT/MADD/MSUB/DIV, signed and unsigned)
// MDU_FAST_MUL_EN: multiply in one CALC cycle with a WIDTH x WIDTH multiplier
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 cancel_i,
    input  logic [2:0]           op_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic [WIDTH-1:0]     hi_i,
    input  logic [WIDTH-1:0]     lo_i,
    output logic                 busy_o,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 div_by_zero_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, ACC, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [1:0]         op_kind;        // op[2:1]: 00 mul, 01 madd, 10 msub, 11 div
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   q_sh;           // multiplier shifting right, or dividend/quotient shifting left
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod;
`ifndef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] mcand;
`endif

    logic               in_neg_a, in_neg_b, in_is_div, accept;
    logic [WIDTH-1:0]   in_a_mag, in_b_mag, a_raw;
    logic               op_is_div, div_zero, last_iter, mul_one_shot;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] prod_fix, acc_result;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Even op codes are the signed variants
    assign in_neg_a  = ~op_i[0] & opdata1_i[WIDTH-1];
    assign in_neg_b  = ~op_i[0] & opdata2_i[WIDTH-1];
    assign in_a_mag  = in_neg_a ? -opdata1_i : opdata1_i;
    assign in_b_mag  = in_neg_b ? -opdata2_i : opdata2_i;
    assign in_is_div = op_i[2] & op_i[1];
    assign accept    = (state == IDLE || state == DONE) && start_i && !cancel_i;

    assign op_is_div = (op_kind == 2'b11);
    assign div_zero  = op_is_div && (b_mag == '0);
    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign a_raw     = sign_a ? -a_mag : a_mag;
    assign trial     = {rem, q_sh[WIDTH-1]} - {1'b0, b_mag};

`ifdef MDU_FAST_MUL_EN
    assign mul_one_shot = !op_is_div;
`else
    assign mul_one_shot = 1'b0;
`endif

    assign busy_o  = (state == CALC) || (state == ACC);
    assign ready_o = (state == DONE);

    always_comb begin
        prod_fix   = (sign_a ^ sign_b) ? -prod : prod;
        quo_fix    = (sign_a ^ sign_b) ? -q_sh : q_sh;
        rem_fix    = sign_a ? -rem : rem;
        acc_result = prod_fix;
        case (op_kind)
            2'b01:   acc_result = acc + prod_fix;
            2'b10:   acc_result = acc - prod_fix;
            2'b11:   acc_result = {rem_fix, quo_fix};
            default: acc_result = prod_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: begin
                if (div_zero)                      state_nxt = DONE;
                else if (mul_one_shot || last_iter) state_nxt = ACC;
            end
            ACC:  state_nxt = DONE;
            DONE: state_nxt = accept ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (cancel_i) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            op_kind       <= '0;
            sign_a        <= 1'b0;
            sign_b        <= 1'b0;
            a_mag         <= '0;
            b_mag         <= '0;
            q_sh          <= '0;
            rem           <= '0;
            acc           <= '0;
            prod          <= '0;
`ifndef MDU_FAST_MUL_EN
            mcand         <= '0;
`endif
            result_o      <= '0;
            div_by_zero_o <= 1'b0;
        end else if (accept) begin
            cnt           <= '0;
            op_kind       <= op_i[2:1];
            sign_a        <= in_neg_a;
            sign_b        <= in_neg_b;
            a_mag         <= in_a_mag;
            b_mag         <= in_b_mag;
            q_sh          <= in_is_div ? in_a_mag : in_b_mag;
            rem           <= '0;
            acc           <= {hi_i, lo_i};
            prod          <= '0;
`ifndef MDU_FAST_MUL_EN
            mcand         <= {{WIDTH{1'b0}}, in_a_mag};
`endif
            div_by_zero_o <= 1'b0;
        end else if (!cancel_i) begin
            if (state == CALC) begin
                cnt <= cnt + CW'(1);
                if (op_is_div) begin
                    if (div_zero) begin
                        result_o      <= {a_raw, {WIDTH{1'b1}}};
                        div_by_zero_o <= 1'b1;
                    end else if (!trial[WIDTH]) begin
                        rem  <= trial[WIDTH-1:0];
                        q_sh <= {q_sh[WIDTH-2:0], 1'b1};
                    end else begin
                        rem  <= {rem[WIDTH-2:0], q_sh[WIDTH-1]};
                        q_sh <= {q_sh[WIDTH-2:0], 1'b0};
                    end
                end else begin
`ifdef MDU_FAST_MUL_EN
                    prod <= {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`else
                    if (q_sh[0]) prod <= prod + mcand;
                    mcand <= mcand << 1;
                    q_sh  <= q_sh >> 1;
`endif
                end
            end else if (state == ACC) begin
                result_o <= acc_result;
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - scoreboard bench for mdu_iter with directed vectors
module tb_mdu_iter;

    localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 3;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_MADD = 3'd2,
                           OP_MSUB = 3'd4, OP_DIV = 3'd6, OP_DIVU = 3'd7;

    logic           clk, rst, start_i, cancel_i;
    logic [2:0]     op_i;
    logic [W-1:0]   opdata1_i, opdata2_i, hi_i, lo_i;
    logic           busy_o, ready_o, div_by_zero_o;
    logic [2*W-1:0] result_o;

    mdu_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .cancel_i(cancel_i), .op_i(op_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .hi_i(hi_i), .lo_i(lo_i),
        .busy_o(busy_o), .ready_o(ready_o), .result_o(result_o), .div_by_zero_o(div_by_zero_o)
    );

    typedef struct {
        logic [63:0] res;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%h required=0x%h", name, act, req);
        end
    endtask

    // Monitor: every ready_o pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (!rst && ready_o) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready: actual=1 required=0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result_o, e.res);
                chk("div_by_zero", 64'(div_by_zero_o), 64'(e.dbz));
                chk("latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Called just after a negedge; returns at the negedge following the accepting edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo, input bit push,
                         input logic [63:0] res, input bit dbz, input int lat);
        exp_t e;
        op_i = op; opdata1_i = a; opdata2_i = b; hi_i = hi; lo_i = lo; start_i = 1'b1;
        if (push) begin
            e.res = res; e.dbz = dbz; e.cyc = cyc + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({"done_", name}, 64'(ready_o), 64'd1);
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo,
                       input logic [63:0] res, input bit dbz, input int lat, input string name);
        issue(op, a, b, hi, lo, 1'b1, res, dbz, lat);
        wait_done(name);
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start_i = 1'b0; cancel_i = 1'b0; op_i = '0;
        opdata1_i = '0; opdata2_i = '0; hi_i = '0; lo_i = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_result", result_o, 64'd0);
        chk("reset_dbz", 64'(div_by_zero_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(OP_MULT, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0, 1'b1, 64'hFFFFFFFF_FFFFFFFA, 1'b0, MUL_LAT);
        chk("busy_after_start", 64'(busy_o), 64'd1);
        wait_done("mult");
        @(negedge clk);
        run(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 64'hFFFFFFFE_00000001, 1'b0, MUL_LAT, "multu");
        run(OP_MADD, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 64'h00000001_00000000, 1'b0, MUL_LAT, "madd");
        run(OP_MSUB, 32'd1, 32'd1, 32'd0, 32'd0, 64'hFFFFFFFF_FFFFFFFF, 1'b0, MUL_LAT, "msub");
        run(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 64'hFFFFFFFF_FFFFFFFD, 1'b0, DIV_LAT, "div_neg");
        run(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 64'h00000000_80000000, 1'b0, DIV_LAT, "div_ovf");
        run(OP_DIVU, 32'd7, 32'd0, 32'd0, 32'd0, 64'h00000007_FFFFFFFF, 1'b1, 2, "divu_zero");
        chk("dbz_hold", 64'(div_by_zero_o), 64'd1);
        chk("result_hold", result_o, 64'h00000007_FFFFFFFF);

        // Cancel mid-divide; a start in the cancel cycle must be ignored too
        issue(OP_DIV, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 64'd0, 1'b0, 0);
        repeat (8) @(negedge clk);
        chk("busy_before_cancel", 64'(busy_o), 64'd1);
        @(negedge clk);
        cancel_i = 1'b1; start_i = 1'b1; op_i = OP_MULTU;
        @(negedge clk);
        cancel_i = 1'b0; start_i = 1'b0;
        chk("busy_after_cancel", 64'(busy_o), 64'd0);
        chk("result_after_cancel", result_o, 64'h00000007_FFFFFFFF);
        chk("dbz_cleared_on_accept", 64'(div_by_zero_o), 64'd0);
        repeat (40) @(negedge clk);
        chk("idle_after_cancel", 64'(busy_o), 64'd0);
        run(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd0, 64'h00000000_0000000C, 1'b0, MUL_LAT, "multu_after_cancel");

        // Start while busy is dropped
        issue(OP_DIVU, 32'd100, 32'd7, 32'd0, 32'd0, 1'b1, 64'h00000002_0000000E, 1'b0, DIV_LAT);
        repeat (5) @(negedge clk);
        start_i = 1'b1; op_i = OP_MULTU; opdata1_i = 32'd5; opdata2_i = 32'd5;
        @(negedge clk);
        start_i = 1'b0;
        chk("busy_during_ignored", 64'(busy_o), 64'd1);
        wait_done("divu_busy");
        @(negedge clk);
        chk("busy_after_ignored", 64'(busy_o), 64'd0);

        // Back-to-back: second start issued in the DONE cycle
        issue(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd0, 1'b1, 64'h00000000_0000000C, 1'b0, MUL_LAT);
        wait_done("b2b_first");
        issue(OP_MULT, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0, 1'b1, 64'hFFFFFFFF_FFFFFFFA, 1'b0, MUL_LAT);
        chk("busy_b2b", 64'(busy_o), 64'd1);
        wait_done("b2b_second");
        @(negedge clk);

        // Reset in the middle of an operation
`ifdef MDU_FAST_MUL_EN
        issue(OP_DIVU, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 64'd0, 1'b0, 0);
`else
        issue(OP_MULT, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0, 1'b0, 64'd0, 1'b0, 0);
`endif
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_ready", 64'(ready_o), 64'd0);
        chk("midrst_result", result_o, 64'd0);
        chk("midrst_dbz", 64'(div_by_zero_o), 64'd0);
        repeat (40) @(negedge clk);
        chk("idle_after_midrst", 64'(busy_o), 64'd0);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised iterative multiply/divide unit that executes MULT/MULTU/MADD/MADDU/MSUB/MSUBU/DIV/DIVU on WIDTH-bit operands and returns a 2·WIDTH-bit {hi,lo} result.

- Sits beside the execute stage, which asserts a stall while `busy_o` is high and writes HI/LO on `ready_o`.
- Replaces the fixed two-cycle multiply-accumulate path and the external 32-bit divider with one FSM-sequenced datapath.
- Adds a pipeline-flush cancel and explicit divide-by-zero reporting.

## Interface
Parameters:
- WIDTH, 32, operand width; result is 2·WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- start_i  in  1  request; accepted only while busy_o=0 and cancel_i=0
- cancel_i  in  1  flush; aborts any operation in progress
- op_i  in  3  0 MULT, 1 MULTU, 2 MADD, 3 MADDU, 4 MSUB, 5 MSUBU, 6 DIV, 7 DIVU
- opdata1_i  in  WIDTH  multiplicand / dividend
- opdata2_i  in  WIDTH  multiplier / divisor
- hi_i, lo_i  in  WIDTH each  accumulator for MADD/MSUB; sampled with start
- busy_o  out  1  operation in progress
- ready_o  out  1  one-cycle completion pulse
- result_o  out  2·WIDTH  {hi,lo}; product in hi:lo; for DIV, hi=remainder, lo=quotient
- div_by_zero_o  out  1  valid with ready_o; divisor was zero

## Operation
FSM states: IDLE, CALC, ACC, DONE.
- **Accept.** In IDLE or DONE, start_i=1 and cancel_i=0 latches op, operands and {hi_i,lo_i}, then goes to CALC.
- **Sign handling.** Signed ops (MULT, MADD, MSUB, DIV) convert operands to magnitudes and record the signs. Unsigned ops use the operands as-is.
- **CALC, multiply.** Shift-add, one multiplier bit per cycle, WIDTH cycles. A counter runs from 0 to WIDTH-1.
- **CALC, divide.** Restoring division, one quotient bit per cycle, WIDTH cycles.
- **Divide by zero.** If divisor=0, CALC lasts one cycle, the iteration is skipped and the FSM goes straight to DONE.
  - result_o = {opdata1, all-ones}.
  - div_by_zero_o=1.
- **ACC.** Applies sign fix, then accumulates.
  - Product is negated when the signs differ.
  - Quotient is negated when the signs differ; remainder takes the dividend's sign.
  - MADD*: {hi,lo}+product. MSUB*: {hi,lo}−product. Both are modulo 2^(2·WIDTH).
- **Signed overflow.** DIV of −2^(WIDTH−1) by −1 gives quotient 2^(WIDTH−1) and remainder 0 (natural wrap, no flag).
- **DONE.** ready_o=1 for exactly this cycle. Next state is IDLE, or CALC if a new start is accepted.
- **Result hold.** result_o and div_by_zero_o hold until the next accepted start. div_by_zero_o clears on accept.
- **cancel_i=1.** In any state, the next state is IDLE. No ready_o pulse; result_o is unchanged; a start in the same cycle is ignored.
- **Start while busy.** Ignored; no queuing.

## Timing
- **Reset values** (any cycle, overrides everything including mid-operation): state IDLE, busy_o=0, ready_o=0, result_o=0, div_by_zero_o=0, counter=0.
- **Nominal latency.** Start sampled at edge N:
  - busy_o=1 from N+1.
  - CALC occupies N+1..N+WIDTH.
  - ACC at N+WIDTH+1.
  - DONE (ready_o=1, busy_o=0) at N+WIDTH+2.
  - Latency WIDTH+2; WIDTH=32 gives 34 cycles.
- **Divide by zero.** CALC at N+1, DONE at N+2, so latency 2.
- **busy_o** is high in CALC and ACC only. Back-to-back issue is allowed in DONE, giving 1 idle-free handoff.
- **Cancel.** cancel_i at cycle M: busy_o=0 at M+1.

## Configuration
- Macro: MDU_FAST_MUL_EN.
- **Defined:** multiply ops finish CALC in one cycle using a single-cycle WIDTH×WIDTH multiplier on the magnitudes.
  - Multiply latency is 3 (CALC N+1, ACC N+2, DONE N+3).
  - Divide is unchanged.
- **Undefined:** iterative shift-add as above; no hardware multiplier is inferred.

## Test plan
All with WIDTH=32 and MDU_FAST_MUL_EN undefined unless noted.
- **MULT signed:** 0xFFFFFFFE (−2) × 3 → result_o=0xFFFFFFFF_FFFFFFFA, ready_o 34 cycles after start. Same case with MDU_FAST_MUL_EN defined → ready_o at 3.
- **MULTU max:** 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE_00000001.
- **MADD / MSUB:**
  - MADD, hi=0, lo=0xFFFFFFFF, 1×1 → 0x00000001_00000000.
  - MSUB, hi=0, lo=0, 1×1 → 0xFFFFFFFF_FFFFFFFF.
- **DIV / DIVU:**
  - DIV −7 / 2 → 0xFFFFFFFF_FFFFFFFD (r=−1, q=−3).
  - DIV 0x80000000 / 0xFFFFFFFF → 0x00000000_80000000.
  - DIVU 7 / 0 → ready_o at cycle 2, div_by_zero_o=1, result_o=0x00000007_FFFFFFFF.
- **Cancel:** cancel_i at cycle 10 of a DIV → busy_o=0 at 11, no ready_o, result_o holds the previous value; a following MULTU 3×4 gives 0x00000000_0000000C.
- **Reset and back-to-back:**
  - rst at cycle 5 of a MULT → all outputs zero the next cycle.
  - start asserted in the DONE cycle → accepted; second ready_o exactly 34 cycles later.
  - start while busy → ignored.
